// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared register offsets, IIR codes and LSR bit positions for the
//           UART register bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] UART_REG_DATA = 3'd0;
    localparam logic [2:0] UART_REG_IER  = 3'd1;
    localparam logic [2:0] UART_REG_IIR  = 3'd2;
    localparam logic [2:0] UART_REG_LCR  = 3'd3;
    localparam logic [2:0] UART_REG_MCR  = 3'd4;
    localparam logic [2:0] UART_REG_LSR  = 3'd5;
    localparam logic [2:0] UART_REG_MSR  = 3'd6;
    localparam logic [2:0] UART_REG_SCR  = 3'd7;

    localparam logic [7:0] UART_IIR_NONE = 8'hC1;
    localparam logic [7:0] UART_IIR_THRE = 8'hC2;
    localparam logic [7:0] UART_IIR_RDA  = 8'hC4;

    localparam int UART_LSR_DR   = 0;
    localparam int UART_LSR_OE   = 1;
    localparam int UART_LSR_THRE = 5;
    localparam int UART_LSR_TEMT = 6;

    localparam int UART_FCR_RX_CLR = 1;
    localparam int UART_FCR_TX_CLR = 2;
    localparam int UART_LCR_DLAB   = 7;

    localparam logic [7:0] UART_LCR_RESET = 8'h03;

    // Receive-data interrupt outranks transmit-empty.
    function automatic logic [7:0] uart_iir(input logic rx_pend, input logic tx_pend);
        if (rx_pend)
            return UART_IIR_RDA;
        else if (tx_pend)
            return UART_IIR_THRE;
        else
            return UART_IIR_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_reg_fifo.sv
// ============================================================================
// Module  : uart_reg_fifo
// Brief   : Byte-wide synchronous FIFO, 2**FIFO_AW entries, with clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reg_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               push_i,
    input  logic [7:0]         push_data_i,
    input  logic               pop_i,
    input  logic               clear_i,
    output logic [7:0]         head_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [FIFO_AW:0]   count_o
);

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               pop_ok;
    logic               push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok)
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/uart_reg_bank.sv
// ============================================================================
// Module  : uart_reg_bank
// Brief   : UART programmer-visible registers, TX/RX FIFOs and interrupt.
//           UART_FIFO_COUNT_EN turns offset 7 into a read-only FIFO level
//           register; otherwise offset 7 is a scratch register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reg_bank
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic [2:0]  adr_i,
    input  logic [7:0]  dat_i,
    output logic [7:0]  dat_o,
    input  logic        we_i,
    input  logic        re_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic        tx_busy_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [15:0] divisor_o,
    output logic [7:0]  lcr_o,
    output logic        int_o
);

    logic       we_q, re_q;
    logic [7:0] dll_q, dll_d;
    logic [7:0] dlm_q, dlm_d;
    logic [7:0] lcr_q, lcr_d;
    logic [1:0] ier_q, ier_d;
    logic       overrun_q, overrun_d;
    logic [7:0] dat_q, dat_d;
    logic       int_q;
`ifndef UART_FIFO_COUNT_EN
    logic [7:0] scr_q, scr_d;
`endif

    logic             we_act, re_act, dlab;
    logic             tx_push, tx_pop, tx_clear;
    logic             rx_pop, rx_clear;
    logic [7:0]       tx_head, rx_head;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic [FIFO_AW:0] tx_count, rx_count;
    logic             rx_pend, tx_pend, overrun_set, lsr_read;
    logic [7:0]       lsr, rd_data;

    // Each bus access holds its strobe for two cycles; only the rising cycle acts.
    assign we_act = we_i & ~we_q;
    assign re_act = re_i & ~re_q;
    assign dlab   = lcr_q[UART_LCR_DLAB];

    assign tx_push  = we_act & (adr_i == UART_REG_DATA) & ~dlab;
    assign tx_pop   = tx_valid_o & tx_ready_i;
    assign tx_clear = we_act & (adr_i == UART_REG_IIR) & dat_i[UART_FCR_TX_CLR];
    assign rx_pop   = re_act & (adr_i == UART_REG_DATA) & ~dlab;
    assign rx_clear = we_act & (adr_i == UART_REG_IIR) & dat_i[UART_FCR_RX_CLR];
    assign lsr_read = re_act & (adr_i == UART_REG_LSR);

    uart_reg_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .push_i      (tx_push),
        .push_data_i (dat_i),
        .pop_i       (tx_pop),
        .clear_i     (tx_clear),
        .head_o      (tx_head),
        .empty_o     (tx_empty),
        .full_o      (tx_full),
        .count_o     (tx_count)
    );

    uart_reg_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .push_i      (rx_valid_i),
        .push_data_i (rx_data_i),
        .pop_i       (rx_pop),
        .clear_i     (rx_clear),
        .head_o      (rx_head),
        .empty_o     (rx_empty),
        .full_o      (rx_full),
        .count_o     (rx_count)
    );

    assign tx_data_o  = tx_head;
    assign tx_valid_o = ~tx_empty;

    // A simultaneous pop makes room, so only an unpaired push into a full FIFO overruns.
    assign overrun_set = rx_valid_i & rx_full & ~(rx_pop & ~rx_empty) & ~rx_clear;

    assign rx_pend = ier_q[0] & ~rx_empty;
    assign tx_pend = ier_q[1] & tx_empty;

    always_comb begin
        lsr                = 8'h00;
        lsr[UART_LSR_DR]   = ~rx_empty;
        lsr[UART_LSR_OE]   = overrun_q;
        lsr[UART_LSR_THRE] = ~tx_full;
        lsr[UART_LSR_TEMT] = tx_empty & ~tx_busy_i;
    end

`ifdef UART_FIFO_COUNT_EN
    logic [3:0] tx_lvl, rx_lvl;
    localparam logic [FIFO_AW:0] LVL_MAX = (FIFO_AW + 1)'(15);
    assign tx_lvl = (tx_count > LVL_MAX) ? 4'hF : 4'(tx_count);
    assign rx_lvl = (rx_count > LVL_MAX) ? 4'hF : 4'(rx_count);
`else
    logic count_unused;
    assign count_unused = ^{tx_count, rx_count};
`endif

    always_comb begin
        rd_data = 8'h00;
        case (adr_i)
            UART_REG_DATA: rd_data = dlab ? dll_q : (rx_empty ? 8'h00 : rx_head);
            UART_REG_IER:  rd_data = dlab ? dlm_q : {6'b000000, ier_q};
            UART_REG_IIR:  rd_data = uart_iir(rx_pend, tx_pend);
            UART_REG_LCR:  rd_data = lcr_q;
            UART_REG_LSR:  rd_data = lsr;
`ifdef UART_FIFO_COUNT_EN
            UART_REG_SCR:  rd_data = {tx_lvl, rx_lvl};
`else
            UART_REG_SCR:  rd_data = scr_q;
`endif
            default:       rd_data = 8'h00;
        endcase
    end

    always_comb begin
        dll_d     = dll_q;
        dlm_d     = dlm_q;
        lcr_d     = lcr_q;
        ier_d     = ier_q;
        overrun_d = overrun_q;
        dat_d     = dat_q;
`ifndef UART_FIFO_COUNT_EN
        scr_d     = scr_q;
`endif
        if (we_act) begin
            case (adr_i)
                UART_REG_DATA: if (dlab) dll_d = dat_i;
                UART_REG_IER: begin
                    if (dlab)
                        dlm_d = dat_i;
                    else
                        ier_d = dat_i[1:0];
                end
                UART_REG_LCR:  lcr_d = dat_i;
`ifndef UART_FIFO_COUNT_EN
                UART_REG_SCR:  scr_d = dat_i;
`endif
                default: ;
            endcase
        end
        if (re_act)
            dat_d = rd_data;
        if (lsr_read)
            overrun_d = 1'b0;
        if (overrun_set)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            dll_q     <= 8'h00;
            dlm_q     <= 8'h00;
            lcr_q     <= UART_LCR_RESET;
            ier_q     <= 2'b00;
            overrun_q <= 1'b0;
            dat_q     <= 8'h00;
            int_q     <= 1'b0;
`ifndef UART_FIFO_COUNT_EN
            scr_q     <= 8'h00;
`endif
        end else begin
            we_q      <= we_i;
            re_q      <= re_i;
            dll_q     <= dll_d;
            dlm_q     <= dlm_d;
            lcr_q     <= lcr_d;
            ier_q     <= ier_d;
            overrun_q <= overrun_d;
            dat_q     <= dat_d;
            int_q     <= rx_pend | tx_pend;
`ifndef UART_FIFO_COUNT_EN
            scr_q     <= scr_d;
`endif
        end
    end

    assign dat_o     = dat_q;
    assign divisor_o = {dlm_q, dll_q};
    assign lcr_o     = lcr_q;
    assign int_o     = int_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_bank.sv
// ============================================================================
// Module  : tb_uart_reg_bank
// Brief   : Directed and randomized checks of uart_reg_bank against a
//           queue-based register model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_reg_bank;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [2:0]  adr_i;
    logic [7:0]  dat_i;
    logic [7:0]  dat_o;
    logic        we_i, re_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i, tx_busy_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [15:0] divisor_o;
    logic [7:0]  lcr_o;
    logic        int_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_sent [17];

    // Register model: plain variables plus queues for the two FIFOs.
    logic [7:0] m_dll, m_dlm, m_lcr, m_scr;
    logic [1:0] m_ier;
    logic       m_ovr;
    logic [7:0] m_txq [$];
    logic [7:0] m_rxq [$];

    always #5 clk = ~clk;

    uart_reg_bank #(.FIFO_AW(4)) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .we_i       (we_i),
        .re_i       (re_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tx_busy_i  (tx_busy_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .divisor_o  (divisor_o),
        .lcr_o      (lcr_o),
        .int_o      (int_o)
    );

    function automatic void model_reset();
        m_dll = 8'h00; m_dlm = 8'h00; m_lcr = 8'h03; m_scr = 8'h00;
        m_ier = 2'b00; m_ovr = 1'b0;
        m_txq.delete(); m_rxq.delete();
    endfunction

    function automatic logic [3:0] sat4(input int n);
        return (n > 15) ? 4'hF : 4'(n);
    endfunction

    function automatic logic model_int();
        return (m_ier[0] && m_rxq.size() > 0) || (m_ier[1] && m_txq.size() == 0);
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] a);
        logic dlab = m_lcr[7];
        case (a)
            3'd0: return dlab ? m_dll : ((m_rxq.size() > 0) ? m_rxq[0] : 8'h00);
            3'd1: return dlab ? m_dlm : {6'b0, m_ier};
            3'd2: begin
                if (m_ier[0] && m_rxq.size() > 0) return 8'hC4;
                if (m_ier[1] && m_txq.size() == 0) return 8'hC2;
                return 8'hC1;
            end
            3'd3: return m_lcr;
            3'd5: return {1'b0, (m_txq.size() == 0) && !tx_busy_i, m_txq.size() < 16,
                          3'b000, m_ovr, m_rxq.size() > 0};
`ifdef UART_FIFO_COUNT_EN
            3'd7: return {sat4(m_txq.size()), sat4(m_rxq.size())};
`else
            3'd7: return m_scr;
`endif
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_read_effects(input logic [2:0] a);
        if (a == 3'd0 && !m_lcr[7] && m_rxq.size() > 0) void'(m_rxq.pop_front());
        if (a == 3'd5) m_ovr = 1'b0;
    endfunction

    function automatic void model_write(input logic [2:0] a, input logic [7:0] d);
        logic dlab = m_lcr[7];
        case (a)
            3'd0: if (dlab) m_dll = d; else if (m_txq.size() < 16) m_txq.push_back(d);
            3'd1: if (dlab) m_dlm = d; else m_ier = d[1:0];
            3'd2: begin
                if (d[1]) m_rxq.delete();
                if (d[2]) m_txq.delete();
            end
            3'd3: m_lcr = d;
            3'd7: begin
`ifndef UART_FIFO_COUNT_EN
                m_scr = d;
`endif
            end
            default: ;
        endcase
    endfunction

    function automatic void model_rx_push(input logic [7:0] d);
        if (m_rxq.size() < 16) m_rxq.push_back(d); else m_ovr = 1'b1;
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        adr_i = a; dat_i = d; we_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        adr_i = a; re_i = 1'b1;
        @(posedge clk); #1;
        d = dat_o;
        @(posedge clk); #1;
        re_i = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(posedge clk); #1;
        rx_valid_i = 1'b1; rx_data_i = d;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic apply_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd [8];
        logic [7:0] d;
        exp_rd = '{8'h00, 8'h00, 8'hC1, 8'h03, 8'h00, 8'h60, 8'h00, 8'h00};
        adr_i = 3'd0; dat_i = 8'h00; we_i = 1'b0; re_i = 1'b0;
        tx_ready_i = 1'b0; tx_busy_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        apply_reset();
        n_tests++;
        if ({tx_valid_o, int_o, dat_o, divisor_o, lcr_o} !== {2'b00, 8'h00, 16'h0000, 8'h03}) begin
            n_fail++;
            $display("FAIL reset_outputs: got txv=%b int=%b dat=%h div=%h lcr=%h required 0 0 00 0000 03",
                     tx_valid_o, int_o, dat_o, divisor_o, lcr_o);
        end
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            n_tests++;
            if (d !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h required %h", i, d, exp_rd[i]);
            end
        end
        n_tests++;
        if ({int_o, tx_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_int_txv: got %b%b required 00", int_o, tx_valid_o);
        end
    endtask

    task automatic test_divisor();
        bus_write(3'd3, 8'h83);
        bus_write(3'd0, 8'h1A);
        bus_write(3'd1, 8'h00);
        bus_write(3'd3, 8'h03);
        n_tests++;
        if (divisor_o !== 16'h001A || lcr_o !== 8'h03) begin
            n_fail++;
            $display("FAIL divisor: got div=%h lcr=%h required 001a 03", divisor_o, lcr_o);
        end
        bus_write(3'd0, 8'hA5);
        n_tests++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL tx_push: got v=%b d=%h required 1 a5", tx_valid_o, tx_data_o);
        end
        bus_write(3'd2, 8'h04);
        n_tests++;
        if (tx_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fcr_tx_clear: got txv=%b required 0", tx_valid_o);
        end
    endtask

    task automatic test_tx_full();
        logic [7:0] d;
        for (int i = 0; i < 17; i++) begin
            tx_sent[i] = 8'($urandom);
            bus_write(3'd0, tx_sent[i]);
        end
        bus_read(3'd5, d);
        n_tests++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL tx_full_lsr: got %h required 00", d);
        end
`ifdef UART_FIFO_COUNT_EN
        bus_read(3'd7, d);
        n_tests++;
        if (d !== 8'hF0) begin
            n_fail++;
            $display("FAIL tx_full_count: got %h required f0", d);
        end
`endif
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        for (int i = 0; i < 17; i++) rx_push(8'(i));
        bus_read(3'd5, d);
        n_tests++;
        if (d !== 8'h03) begin
            n_fail++;
            $display("FAIL rx_overrun_lsr: got %h required 03", d);
        end
        bus_read(3'd5, d);
        n_tests++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL rx_overrun_cleared: got %h required 01", d);
        end
`ifdef UART_FIFO_COUNT_EN
        bus_read(3'd7, d);
        n_tests++;
        if (d !== 8'hFF) begin
            n_fail++;
            $display("FAIL rx_full_count: got %h required ff", d);
        end
`endif
        for (int i = 0; i < 16; i++) begin
            bus_read(3'd0, d);
            n_tests++;
            if (d !== 8'(i)) begin
                n_fail++;
                $display("FAIL rx_order[%0d]: got %h required %h", i, d, 8'(i));
            end
        end
        bus_read(3'd0, d);
        n_tests++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL rx_empty_read: got %h required 00", d);
        end
    endtask

    task automatic test_tx_drain();
        logic [7:0] got [$];
        @(posedge clk); #1;
        tx_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!tx_valid_o) break;
            got.push_back(tx_data_o);
            @(posedge clk); #1;
        end
        tx_ready_i = 1'b0;
        n_tests++;
        if (got.size() != 16) begin
            n_fail++;
            $display("FAIL tx_drain_len: got %0d bytes required 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== tx_sent[i]) begin
                n_fail++;
                $display("FAIL tx_drain[%0d]: got %h required %h", i, got[i], tx_sent[i]);
            end
        end
    endtask

    task automatic test_clear_vs_push();
        logic [7:0] d;
        rx_push(8'h77);
        @(posedge clk); #1;
        adr_i = 3'd2; dat_i = 8'h02; we_i = 1'b1;
        rx_valid_i = 1'b1; rx_data_i = 8'h88;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        @(posedge clk); #1;
        we_i = 1'b0;
        bus_read(3'd5, d);
        n_tests++;
        if (d !== 8'h60) begin
            n_fail++;
            $display("FAIL clear_wins_lsr: got %h required 60", d);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [7:0] d;
        logic [7:0] exp_rd [4];
        logic [7:0] got_rd [4];
        exp_rd = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
        rx_push(8'hAA);
        rx_push(8'hBB);
        @(posedge clk); #1;
        adr_i = 3'd0; re_i = 1'b1;
        rx_valid_i = 1'b1; rx_data_i = 8'hCC;
        @(posedge clk); #1;
        got_rd[0] = dat_o;
        rx_valid_i = 1'b0;
        @(posedge clk); #1;
        re_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            bus_read(3'd0, d);
            got_rd[i] = d;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got_rd[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL push_pop_same[%0d]: got %h required %h", i, got_rd[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_interrupts();
        logic [7:0] d;
        bus_write(3'd1, 8'h03);
        bus_read(3'd2, d);
        n_tests++;
        if (d !== 8'hC2 || int_o !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_thre: got iir=%h int=%b required c2 1", d, int_o);
        end
        rx_push(8'h5A);
        bus_read(3'd2, d);
        n_tests++;
        if (d !== 8'hC4 || int_o !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rda: got iir=%h int=%b required c4 1", d, int_o);
        end
        bus_read(3'd0, d);
        bus_read(3'd2, d);
        n_tests++;
        if (d !== 8'hC2) begin
            n_fail++;
            $display("FAIL irq_after_pop: got %h required c2", d);
        end
        bus_write(3'd1, 8'h01);
        bus_read(3'd2, d);
        n_tests++;
        if (d !== 8'hC1 || int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_none: got iir=%h int=%b required c1 0", d, int_o);
        end
        bus_write(3'd1, 8'h00);
    endtask

    task automatic test_strobe_hold();
        logic [7:0] d;
        logic [7:0] exp_rd [4];
        logic [7:0] got_rd [4];
        exp_rd = '{8'h11, 8'h22, 8'h33, 8'h00};
        rx_push(8'h11);
        rx_push(8'h22);
        rx_push(8'h33);
        bus_read(3'd0, d);
        got_rd[0] = d;
`ifdef UART_FIFO_COUNT_EN
        bus_read(3'd7, d);
        n_tests++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL strobe_hold_count: got %h required 02", d);
        end
`endif
        for (int i = 1; i < 4; i++) begin
            bus_read(3'd0, d);
            got_rd[i] = d;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got_rd[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL strobe_hold[%0d]: got %h required %h", i, got_rd[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bus_write(3'd3, 8'h1B);
        bus_write(3'd0, 8'h3C);
        rx_push(8'h4D);
        @(posedge clk); #3;
        wb_rst_i = 1'b1;
        #1;
        n_tests++;
        if (tx_valid_o !== 1'b0 || lcr_o !== 8'h03) begin
            n_fail++;
            $display("FAIL reset_async: got txv=%b lcr=%h required 0 03", tx_valid_o, lcr_o);
        end
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        bus_read(3'd5, d);
        n_tests++;
        if (d !== 8'h60) begin
            n_fail++;
            $display("FAIL reset_mid_lsr: got %h required 60", d);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, e;
        logic [2:0] a;
        apply_reset();
        model_reset();
        for (int k = 0; k < 300; k++) begin
            tx_busy_i = 1'($urandom);
            a = 3'($urandom);
            d = 8'($urandom);
            case ($urandom % 4)
                0: begin
                    bus_write(a, d);
                    model_write(a, d);
                end
                1, 2: begin
                    e = model_read(a);
                    model_read_effects(a);
                    bus_read(a, d);
                    n_tests++;
                    if (d !== e) begin
                        n_fail++;
                        $display("FAIL rand_read[%0d] off %0d: got %h required %h", k, a, d, e);
                    end
                end
                default: begin
                    rx_push(d);
                    model_rx_push(d);
                end
            endcase
            @(posedge clk); #1;
            n_tests++;
            if (int_o !== model_int() || tx_valid_o !== (m_txq.size() > 0)) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got int=%b txv=%b required %b %b",
                         k, int_o, tx_valid_o, model_int(), m_txq.size() > 0);
            end
            if (m_txq.size() > 0) begin
                n_tests++;
                if (tx_data_o !== m_txq[0]) begin
                    n_fail++;
                    $display("FAIL rand_txhead[%0d]: got %h required %h", k, tx_data_o, m_txq[0]);
                end
            end
        end
        n_tests++;
        if (divisor_o !== {m_dlm, m_dll} || lcr_o !== m_lcr) begin
            n_fail++;
            $display("FAIL rand_regs: got div=%h lcr=%h required %h %h",
                     divisor_o, lcr_o, {m_dlm, m_dll}, m_lcr);
        end
        tx_busy_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_divisor();
        test_tx_full();
        test_rx_overrun();
        test_tx_drain();
        test_clear_vs_push();
        test_push_pop_same_cycle();
        test_interrupts();
        test_strobe_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_reg_bank.md
# uart_reg_bank

UART register bank sitting directly downstream of the Wishbone slave stage: it consumes that stage's write/read strobes plus the bus address and data, and implements the byte-wide programmer-visible registers. It holds a 16-entry TX FIFO feeding the transmitter, a 16-entry RX FIFO filled by the receiver, the baud divisor latch, the line control register and the interrupt output.

## Interface
- FIFO_AW, 4, log2 of each FIFO depth (depth 16)
- clk  in  1  system clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- adr_i  in  3  register offset, taken from the bus address
- dat_i  in  8  write data
- dat_o  out  8  registered read data
- we_i  in  1  write strobe from the Wishbone stage
- re_i  in  1  read strobe from the Wishbone stage
- tx_data_o  out  8  head of the TX FIFO
- tx_valid_o  out  1  TX FIFO not empty
- tx_ready_i  in  1  transmitter pops the head when tx_valid_o is high
- tx_busy_i  in  1  transmitter is shifting a character
- rx_data_i  in  8  received character
- rx_valid_i  in  1  one-cycle push of rx_data_i
- divisor_o  out  16  baud divisor {DLM, DLL}
- lcr_o  out  8  line control register
- int_o  out  1  registered interrupt request

## Operation
- Strobe qualification: we_i and re_i stay high for 2 cycles per access (strobe cycle plus ack cycle). Side effects act only on the first cycle: act = strobe & ~strobe_d, where strobe_d is the strobe registered one cycle earlier. A back-to-back access needs the strobe to drop first, so it is never merged with the previous one.
- DLAB = lcr_o[7]. Register map:
  - Offset 0: DLAB=0: read pops RX, write pushes TX. DLAB=1: DLL, read/write.
  - Offset 1: DLAB=0: IER[1:0] (bit0 RX available, bit1 TX empty); other bits read 0. DLAB=1: DLM, read/write.
  - Offset 2: read IIR: 8'hC4 when RX interrupt pending, else 8'hC2 when TX-empty interrupt pending, else 8'hC1. RX has priority. Write FCR: bit1 clears RX FIFO, bit2 clears TX FIFO; nothing is stored.
  - Offset 3: LCR, full 8 bits read/write.
  - Offset 5: LSR, read only: bit0 RX not empty; bit1 overrun, cleared by the LSR read; bit5 TX FIFO not full; bit6 TX FIFO empty & ~tx_busy_i; other bits 0.
  - Offset 7: see Configuration.
  - Offsets 4 and 6: read 8'h00, writes ignored.
- Pending interrupt = (IER[0] & RX not empty) | (IER[1] & TX FIFO empty). int_o is that value registered.
- Boundary cases:
  - TX write while full: data dropped.
  - RX push while full: data dropped, overrun set.
  - RX read while empty: returns 8'h00, no state change.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged, both happen.
  - FCR clear in the same cycle as a push to that FIFO: the clear wins.
  - Pointers wrap modulo 16. Count is FIFO_AW+1 bits wide.

## Timing
- Read: dat_o is loaded on the clock edge that ends the first strobe cycle, so it is valid in the ack cycle. An RX pop takes effect on that same edge.
- Write: the register or FIFO updates on the edge that ends the first strobe cycle.
- tx_valid_o and tx_data_o are combinational from the FIFO state. A pop happens on the edge where tx_valid_o & tx_ready_i.
- int_o lags a state change by 1 cycle.
- Reset values: dat_o 8'h00, DLL/DLM 0 (divisor_o 16'h0000; the transmitter holds off while the divisor is 0), lcr_o 8'h03, IER 0, overrun 0, both FIFOs empty, tx_valid_o 0, int_o 0.
- Reset asserted mid-operation discards FIFO contents immediately.

## Configuration
- UART_FIFO_COUNT_EN defined: offset 7 is read only and returns {TX count[3:0], RX count[3:0]}. A full FIFO of 16 saturates to 4'hF. Writes are ignored.
- UART_FIFO_COUNT_EN undefined: offset 7 is an 8-bit scratch register, read/write, reset 8'h00.

## Structure
- Shared package uart_pkg holds:
  - register offset constants (UART_REG_DATA=0 … UART_REG_SCR=7)
  - IIR codes (8'hC1, 8'hC2, 8'hC4)
  - LSR bit indices
  - the LCR reset value 8'h03
- One sub-module, uart_reg_fifo: a synchronous FIFO, 8 bits wide, 2**FIFO_AW entries, with push, pop, clear, empty, full and count. It is instantiated twice, once for TX and once for RX.

## Test plan
- After reset, read all 8 offsets: 8'h00, 8'h00, 8'hC1, 8'h03, 8'h00, 8'h60, 8'h00, 8'h00. int_o=0 and tx_valid_o=0.
- Set LCR=8'h83, write DLL=8'h1A and DLM=8'h00, then set LCR=8'h03: divisor_o=16'h001A. A write to offset 0 pushes TX and tx_data_o equals the written byte.
- Write 17 bytes to TX with tx_ready_i=0: count saturates at 16 and LSR bit5=0. Releasing tx_ready_i drains the first 16 bytes in order, and the 17th byte never appears.
- Push 17 RX bytes 8'h00 … 8'h10: LSR reads 8'h03, and a second LSR read returns 8'h01. Reading offset 0 sixteen times returns 8'h00 … 8'h0F, and the next read returns 8'h00.
- Set IER=8'h03 with both FIFOs empty: IIR=8'hC2 and int_o=1. Push one RX byte: IIR=8'hC4. Pop it: IIR returns to 8'hC2.
- Hold re_i high for 2 cycles on offset 0 with 3 entries in RX: exactly 1 pop (RX count goes 3 to 2).
